// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter for a small register bank.
// One write per two cycles, snapshot at grant, commit one cycle later.
module reg_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int W = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] waddr,
  input  logic [NREQ*W-1:0]  wdata,
  input  logic             clear,
  input  logic [AW-1:0]    raddr,
  output logic [W-1:0]     rdata,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    data_q, data_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            we;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     j;
  logic [AW-1:0]   sel_addr;
  logic [W-1:0]    sel_data;

  logic [W-1:0]    bank [NREG];

  // first requester at or after ptr, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr_q} + (IW+1)'(k);
      if (j >= (IW+1)'(NREQ))
        j = j - (IW+1)'(NREQ);
      if (!win_vld && req[j[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = j[IW-1:0];
      end
    end
  end

  // pick the winner's address and data slices
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IW'(k)) begin
        sel_addr = waddr[k*AW +: AW];
        sel_data = wdata[k*W +: W];
      end
    end
  end

  // next state, snapshot and commit enable
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = '0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          idx_d   = win_idx;
          addr_d  = sel_addr;
          data_d  = sel_data;
          grant_d = NREQ'(1) << win_idx;
        end
      end
      GRANT: begin
        we      = 1'b1;
        state_d = IDLE;
        ptr_d   = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
      end
    endcase
  end

  // FSM, pointer, snapshot and grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  // bank storage: clear beats a same-edge commit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int r = 0; r < NREG; r++)
        bank[r] <= '0;
    end else if (we) begin
      bank[addr_q] <= data_q;
    end
  end

  assign rdata = bank[raddr];
  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed checks of arbitration,
// snapshot, clear and reset behaviour.
module tb_reg_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        clear;
  logic [1:0]  raddr;
  logic [3:0]  rdata;
  logic [3:0]  grant;
  logic        busy;

  int checks;
  int failures;

  reg_bank_arbiter #(.NREQ(4), .NREG(4), .W(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .waddr(waddr),
    .wdata(wdata),
    .clear(clear),
    .raddr(raddr),
    .rdata(rdata),
    .grant(grant),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [3:0] exp,
                    input string tag);
    raddr = a;
    #1;
    chk(tag, {28'd0, rdata}, {28'd0, exp});
  endtask

  task automatic slot(input int i, input logic [1:0] a,
                      input logic [3:0] d);
    waddr[i*2 +: 2] = a;
    wdata[i*4 +: 4] = d;
  endtask

  task automatic gb(input string tag, input logic [3:0] g,
                    input logic b);
    chk({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  logic [3:0] rr [8];

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req = '0;
    waddr = '0;
    wdata = '0;
    clear = 1'b0;
    raddr = '0;

    // reset, single request
    cyc();
    cyc();
    gb("rst", 4'b0000, 1'b0);
    rd(2'd0, 4'h0, "rst_r0");
    rd(2'd3, 4'h0, "rst_r3");
    reset = 1'b0;
    slot(0, 2'd2, 4'hA);
    req = 4'b0001;
    cyc();
    gb("single", 4'b0001, 1'b1);
    req = 4'b0000;
    cyc();
    gb("single_done", 4'b0000, 1'b0);
    rd(2'd2, 4'hA, "single_r2");
    rd(2'd1, 4'h0, "single_r1");

    // round robin from ptr=0
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd(2'd2, 4'h0, "rst2_r2");
    for (int i = 0; i < 4; i++)
      slot(i, 2'(i), 4'(i));
    req = 4'b1111;
    rr[0] = 4'b0001; rr[1] = 4'b0000;
    rr[2] = 4'b0010; rr[3] = 4'b0000;
    rr[4] = 4'b0100; rr[5] = 4'b0000;
    rr[6] = 4'b1000; rr[7] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("rr_%0d", i), {28'd0, grant}, {28'd0, rr[i]});
    end
    cyc();
    chk("rr_wrap", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    cyc();
    for (int i = 0; i < 4; i++)
      rd(2'(i), 4'(i), $sformatf("rr_bank%0d", i));

    // ptr=1 -> serve 2 to reach ptr=3
    req = 4'b0100;
    cyc();
    gb("p3_setup", 4'b0100, 1'b1);
    req = 4'b0000;
    cyc();
    req = 4'b0101;
    cyc();
    gb("wrap_first", 4'b0001, 1'b1);
    req = 4'b0100;
    cyc();
    cyc();
    gb("wrap_second", 4'b0100, 1'b1);
    req = 4'b0000;
    cyc();
    req = 4'b1001;
    cyc();
    gb("p3_wins", 4'b1000, 1'b1);
    req = 4'b0000;
    cyc();

    // snapshot, then withdraw (ptr=0)
    slot(1, 2'd1, 4'h5);
    req = 4'b0010;
    cyc();
    gb("snap", 4'b0010, 1'b1);
    slot(1, 2'd1, 4'hF);
    req = 4'b0000;
    cyc();
    rd(2'd1, 4'h5, "snap_r1");
    req = 4'b0100;
    #2;
    req = 4'b0000;
    cyc();
    gb("withdraw", 4'b0000, 1'b0);

    // clear on commit edge (ptr=2)
    slot(2, 2'd1, 4'h7);
    req = 4'b0110;
    cyc();
    gb("clr_grant", 4'b0100, 1'b1);
    req = 4'b0010;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    gb("clr_commit", 4'b0000, 1'b0);
    rd(2'd1, 4'h0, "clr_r1");
    rd(2'd2, 4'h0, "clr_r2");
    rd(2'd3, 4'h0, "clr_r3");
    cyc();
    gb("clr_next", 4'b0010, 1'b1);
    req = 4'b0000;
    cyc();
    rd(2'd1, 4'hF, "clr_next_r1");

    // reset during GRANT (ptr=2)
    slot(0, 2'd3, 4'h9);
    req = 4'b0001;
    cyc();
    gb("mid_grant", 4'b0001, 1'b1);
    reset = 1'b1;
    req = 4'b0000;
    cyc();
    reset = 1'b0;
    gb("mid_rst", 4'b0000, 1'b0);
    rd(2'd3, 4'h0, "mid_r3");
    rd(2'd1, 4'h0, "mid_r1");
    req = 4'b0011;
    cyc();
    gb("mid_ptr0", 4'b0001, 1'b1);
    req = 4'b0000;
    cyc();
    rd(2'd3, 4'h9, "mid_after_r3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter and controller for a small bank of 4-bit enable/reset registers. Up to NREQ requesters compete for write access. The block grants one requester per transaction, snapshots that requester's address and data, and drives the enable of exactly one bank register. It sits between multiple producers and the shared register storage, and it also provides a combinational read port and a bank-wide clear.

## Interface
- NREQ, 4: number of requesters (2..8)
- NREG, 4: number of registers in the bank (power of two, 2..16)
- W, 4: register width in bits
- AW, $clog2(NREG): register address width (derived, not overridden)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request, level
- waddr  input  NREQ*AW  requester i's target register in bits [i*AW +: AW]
- wdata  input  NREQ*W  requester i's write data in bits [i*W +: W]
- clear  input  1  synchronous bank clear, level
- raddr  input  AW  read address
- rdata  output  W  bank[raddr], combinational
- grant  output  NREQ  one-hot grant, registered; high for exactly one cycle per transaction
- busy  output  1  high while in GRANT state

## Operation
- Storage: NREG registers of W bits each, bank[0..NREG-1].
- Priority pointer ptr has range 0..NREQ-1.
- States: IDLE and GRANT. Reset state is IDLE.
- Reset (reset=1 at a clock edge) takes priority over everything:
  - bank all 0, ptr=0, state=IDLE, grant=0, busy=0.
  - Any in-flight transaction is abandoned and no write commits.
- IDLE, at an edge with req != 0:
  - Winner i is the first index with req[i]=1, searching ptr, ptr+1, …, wrapping modulo NREQ.
  - Latch i, waddr slice i and wdata slice i as a snapshot.
  - Set grant = one-hot(i) and move to GRANT.
- IDLE, at an edge with req == 0: stay in IDLE, grant=0.
- GRANT, at the next edge:
  - Commit bank[snap_addr] <= snap_data. This is the only register enabled; all other registers hold.
  - Set ptr <= (i+1) mod NREQ, grant <= 0, and return to IDLE.
- GRANT never lasts more than one cycle. It cannot be stalled or cancelled except by reset.
- Requester protocol:
  - Hold req, waddr and wdata stable until grant[i] is seen high.
  - Deassert req in the cycle grant[i] is high.
  - If req[i] is still high at the following IDLE edge, it is a new request and is arbitrated normally.
- Dropping req in IDLE before the sampling edge withdraws the request with no effect.
- Dropping req during GRANT does not cancel the write; the data was already captured.
- Changes to waddr or wdata after the IDLE sampling edge do not affect the committed write.
- clear=1 at an edge sets all bank registers to 0.
  - If the same edge is a GRANT commit edge, clear wins and the write is discarded.
  - ptr still advances, and the FSM still returns to IDLE.
- clear does not affect the FSM, ptr or arbitration. An IDLE edge with clear=1 and req != 0 still grants.
- The read port has no arbitration: rdata = bank[raddr] at all times. A committed write is visible on rdata in the cycle after the commit edge.

## Timing
- Edge 0 (IDLE, req sampled) → grant and busy high in cycle 1 → bank write and ptr update at edge 1 → new value on rdata in cycle 2.
- Throughput: at most one write per 2 cycles. Back-to-back grants under continuous requests fall on edges 0, 2, 4, ….
- Arbitration latency from req rising, when uncontested and in IDLE: grant visible the next cycle.
- Worst-case wait under full load: NREQ transactions (2*NREQ cycles) before grant.
- Fairness: after requester i is served, i has lowest priority for the next arbitration.
- ptr wraps from NREQ-1 to 0.
- All outputs except rdata are registered. Reset values: grant=0, busy=0, rdata=0 (bank cleared).

## Test plan
- Reset, then single request: reset high 2 cycles. Then req=0001, waddr0=2, wdata0=4'hA → grant=0001 and busy=1 for one cycle. bank[2]=A; raddr=2 shows A two cycles after req is sampled. ptr=1.
- All requesting, round robin: req=1111 held continuously, each requester writing its own index to reg i, starting from ptr=0. Grants are 0001, 0010, 0100, 1000, 0001 on every second cycle; bank = {3,2,1,0}.
- Pointer wrap and skip: ptr=3, req=0101 → grant 0001 first, then 0100. With req=1000 present and ptr=3, requester 3 wins over requester 0.
- Snapshot and withdraw: requester 1 changes wdata from 5 to F in the GRANT cycle, and its register gets 5. Requester 2 drops req before the sampling edge and receives no grant.
- clear vs commit: clear=1 on the GRANT commit edge of a write of 7 to reg 1. All registers become 0 and reg 1 stays 0. ptr advances and the next pending request is still granted.
- Reset mid-transaction: reset=1 during GRANT. No write commits, grant and busy go to 0 the next cycle, ptr=0, and all rdata reads return 0.
